// File: rtl/mem_lsu.sv
// MEM-stage load/store unit. Takes the instruction held in the EX/MEM register,
// runs one word-aligned access on the data bus, aligns load data, builds store
// strobes and registers the write-back result (MEM/WB boundary).
//
// Bus handshake: a request is offered with dbus_req_valid=1. It is accepted on
// the first clk edge where dbus_req_valid and dbus_req_ready are both high.
// Until that edge, valid stays high and addr/we/wstrb/wdata do not change.
// After acceptance, the access completes on the first edge with
// dbus_rsp_valid=1. Responses outside WAIT are ignored.
module mem_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rs2_val_for_store,
  input  logic [4:0]  mem_rd_addr,
  input  logic        mem_reg_write,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic [1:0]  mem_wb_sel,
  input  logic [1:0]  mem_load_size,
  input  logic [1:0]  mem_store_size,
  input  logic        mem_load_signed,
  input  logic [31:0] mem_wb_candidate,
  input  logic        mem_csr_hit,
  input  logic [31:0] mem_csr_data,
  output logic        dbus_req_valid,
  input  logic        dbus_req_ready,
  output logic [31:0] dbus_addr,
  output logic        dbus_we,
  output logic [3:0]  dbus_wstrb,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_rsp_valid,
  input  logic [31:0] dbus_rdata,
  output logic        stall_o,
  output logic [4:0]  wb_rd_addr,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t state, state_next;

  // Latched access context, held stable while the bus access is in flight.
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [4:0]  rd_q;
  logic        regw_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [15:0] tcnt;

  logic        acc;
  logic [1:0]  acc_size;
  logic        misaligned;
  logic        start;
  logic        timed_out;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] load_word;
  logic [31:0] load_data;
  logic [31:0] nonmem_data;

  // A store wins when both read and write are flagged.
  assign acc        = mem_mem_read | mem_mem_write;
  assign acc_size   = mem_mem_write ? mem_store_size : mem_load_size;
  assign misaligned = ((acc_size == 2'b01) & mem_alu_result[0]) |
                      (acc_size[1] & (mem_alu_result[1:0] != 2'b00));
  assign start      = acc & ~misaligned;
  assign timed_out  = (tcnt == TIMEOUT_LAST);

  // Store lane replication and byte strobes from the current EX/MEM instruction.
  always_comb begin
    st_wdata = mem_rs2_val_for_store;
    st_wstrb = 4'b1111;
    case (mem_store_size)
      2'b00: begin
        st_wdata = {4{mem_rs2_val_for_store[7:0]}};
        st_wstrb = 4'b0001 << mem_alu_result[1:0];
      end
      2'b01: begin
        st_wdata = {2{mem_rs2_val_for_store[15:0]}};
        st_wstrb = 4'b0011 << mem_alu_result[1:0];
      end
      default: begin
        st_wdata = mem_rs2_val_for_store;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load alignment: shifting by the byte lane also centres an aligned half.
  always_comb begin
    load_word = rdata_q >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_data = signed_q ? {{24{load_word[7]}}, load_word[7:0]}
                                    : {24'h0, load_word[7:0]};
      2'b01:   load_data = signed_q ? {{16{load_word[15]}}, load_word[15:0]}
                                    : {16'h0, load_word[15:0]};
      default: load_data = rdata_q;
    endcase
  end

  // Write-back value for non-memory ops; load-select without an access falls back to ALU.
  always_comb begin
    if (mem_csr_hit) begin
      nonmem_data = mem_csr_data;
    end else if (mem_wb_sel[1]) begin
      nonmem_data = mem_wb_candidate;
    end else begin
      nonmem_data = mem_alu_result;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_REQ;
      S_REQ:   if (dbus_req_ready) state_next = S_WAIT;
      S_WAIT:  if (dbus_rsp_valid || timed_out) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Bus outputs come only from latched context, so they hold still during REQ.
  always_comb begin
    dbus_req_valid = (state == S_REQ);
    dbus_addr      = 32'h0;
    dbus_we        = 1'b0;
    dbus_wstrb     = 4'b0000;
    dbus_wdata     = 32'h0;
    if (state == S_REQ) begin
      dbus_addr  = {addr_q[31:2], 2'b00};
      dbus_we    = we_q;
      dbus_wstrb = wstrb_q;
      dbus_wdata = wdata_q;
    end
  end

  // Freeze upstream while an access is pending; forced low during reset.
  assign stall_o   = rst_n & (((state == S_IDLE) & start) |
                              (state == S_REQ) | (state == S_WAIT));
  assign dbg_state = state;

  // Access context, timeout counter, pulses and the MEM/WB register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q       <= 32'h0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'b0000;
      rd_q         <= 5'd0;
      regw_q       <= 1'b0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
      tcnt         <= 16'h0;
      wb_rd_addr   <= 5'd0;
      wb_reg_write <= 1'b0;
      wb_data      <= 32'h0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (acc) begin
            // Memory op: WB sees a bubble until the access finishes (or never, if misaligned).
            wb_rd_addr   <= mem_rd_addr;
            wb_reg_write <= 1'b0;
            wb_data      <= 32'h0;
            if (misaligned) begin
              misalign_o <= 1'b1;
            end else begin
              addr_q   <= mem_alu_result;
              size_q   <= acc_size;
              signed_q <= mem_load_signed;
              we_q     <= mem_mem_write;
              wdata_q  <= mem_mem_write ? st_wdata : 32'h0;
              wstrb_q  <= mem_mem_write ? st_wstrb : 4'b0000;
              rd_q     <= mem_rd_addr;
              regw_q   <= mem_reg_write;
              err_q    <= 1'b0;
            end
          end else begin
            wb_rd_addr   <= mem_rd_addr;
            wb_reg_write <= mem_reg_write;
            wb_data      <= nonmem_data;
          end
        end
        S_REQ: begin
          wb_reg_write <= 1'b0;
          tcnt         <= 16'h0;
        end
        S_WAIT: begin
          wb_reg_write <= 1'b0;
          tcnt         <= tcnt + 16'h1;
          if (dbus_rsp_valid) begin
            rdata_q <= dbus_rdata;
          end else if (timed_out) begin
            rdata_q   <= 32'h0;
            err_q     <= 1'b1;
            bus_err_o <= 1'b1;
          end
        end
        S_DONE: begin
          wb_rd_addr   <= rd_q;
          wb_reg_write <= regw_q & ~we_q & ~err_q;
          if (we_q || err_q) begin
            wb_data <= 32'h0;
          end else if (mem_csr_hit) begin
            wb_data <= mem_csr_data;
          end else begin
            wb_data <= load_data;
          end
        end
        default: wb_reg_write <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: scenario tasks drive the EX/MEM inputs and a
// responsive bus, expected write-back and bus requests go through queues.
module tb_mem_lsu;

  localparam int TO = 255;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_rs2_val_for_store;
  logic [4:0]  mem_rd_addr;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic [1:0]  mem_wb_sel;
  logic [1:0]  mem_load_size;
  logic [1:0]  mem_store_size;
  logic        mem_load_signed;
  logic [31:0] mem_wb_candidate;
  logic        mem_csr_hit;
  logic [31:0] mem_csr_data;
  logic        dbus_req_valid;
  logic        dbus_req_ready;
  logic [31:0] dbus_addr;
  logic        dbus_we;
  logic [3:0]  dbus_wstrb;
  logic [31:0] dbus_wdata;
  logic        dbus_rsp_valid;
  logic [31:0] dbus_rdata;
  logic        stall_o;
  logic [4:0]  wb_rd_addr;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        misalign_o;
  logic        bus_err_o;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [37:0] exp_q[$];   // {rd, reg_write, data}
  logic [68:0] bus_q[$];   // {addr, we, wstrb, wdata}

  mem_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_alu_result(mem_alu_result), .mem_rs2_val_for_store(mem_rs2_val_for_store),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_wb_sel(mem_wb_sel), .mem_load_size(mem_load_size),
    .mem_store_size(mem_store_size), .mem_load_signed(mem_load_signed),
    .mem_wb_candidate(mem_wb_candidate), .mem_csr_hit(mem_csr_hit),
    .mem_csr_data(mem_csr_data),
    .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready),
    .dbus_addr(dbus_addr), .dbus_we(dbus_we), .dbus_wstrb(dbus_wstrb),
    .dbus_wdata(dbus_wdata), .dbus_rsp_valid(dbus_rsp_valid), .dbus_rdata(dbus_rdata),
    .stall_o(stall_o), .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .dbg_state(dbg_state)
  );

  // Clock and global watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    mem_alu_result = 32'h0; mem_rs2_val_for_store = 32'h0; mem_rd_addr = 5'd0;
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_mem_write = 1'b0;
    mem_wb_sel = 2'b00; mem_load_size = 2'b00; mem_store_size = 2'b00;
    mem_load_signed = 1'b0; mem_wb_candidate = 32'h0; mem_csr_hit = 1'b0;
    mem_csr_data = 32'h0; dbus_req_ready = 1'b0; dbus_rsp_valid = 1'b0;
    dbus_rdata = 32'h0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [1:0] size,
                            input logic sgn, input logic [4:0] rd);
    drive_idle();
    mem_alu_result = addr; mem_load_size = size; mem_load_signed = sgn;
    mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_rd_addr = rd; mem_wb_sel = 2'b01;
  endtask

  // Stores carry reg_write=1 on purpose: the unit must still suppress write-back.
  task automatic drive_store(input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] data, input logic [4:0] rd);
    drive_idle();
    mem_alu_result = addr; mem_store_size = size; mem_rs2_val_for_store = data;
    mem_mem_write = 1'b1; mem_reg_write = 1'b1; mem_rd_addr = rd;
  endtask

  task automatic drive_alu(input logic [31:0] res, input logic [1:0] sel,
                           input logic [31:0] cand, input logic [4:0] rd, input logic we,
                           input logic csr_hit, input logic [31:0] csr_data);
    drive_idle();
    mem_alu_result = res; mem_wb_sel = sel; mem_wb_candidate = cand; mem_rd_addr = rd;
    mem_reg_write = we; mem_csr_hit = csr_hit; mem_csr_data = csr_data;
  endtask

  function automatic logic [31:0] load_model(input logic [31:0] addr, input logic [1:0] size,
                                             input logic sgn, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (addr[1:0])
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    if (size == 2'b00) return sgn ? {{24{b[7]}}, b} : {24'h0, b};
    if (size == 2'b01) return sgn ? {{16{h[15]}}, h} : {16'h0, h};
    return rdata;
  endfunction

  // Bus responder starting in the cycle the instruction is presented. Returns
  // when the FSM reaches DONE (or the cycle budget runs out).
  task automatic run_bus(input int ready_wait, input int rsp_wait, input logic [31:0] rdata,
                         input bit respond, output int stall_cycles, output int req_count,
                         output bit stable_ok, output logic [68:0] req_seen,
                         output bit done_seen, output bit err_seen);
    logic [68:0] cur;
    bit first = 1'b1;
    bit accepted = 1'b0;
    int wait_cnt = 0;
    int rsp_cnt = 0;
    stall_cycles = 0; req_count = 0; stable_ok = 1'b1; req_seen = '0;
    done_seen = 1'b0; err_seen = 1'b0;
    #1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (stall_o) stall_cycles++;
      if (dbg_state == ST_DONE) begin
        done_seen = 1'b1;
        err_seen = bus_err_o;
        break;
      end
      dbus_req_ready = 1'b0;
      dbus_rsp_valid = 1'b0;
      if (dbus_req_valid) begin
        cur = {dbus_addr, dbus_we, dbus_wstrb, dbus_wdata};
        if (first) begin
          req_seen = cur;
          first = 1'b0;
        end else if (cur !== req_seen) begin
          stable_ok = 1'b0;
        end
        if (accepted) begin
          req_count++;
        end else if (wait_cnt >= ready_wait) begin
          dbus_req_ready = 1'b1;
          accepted = 1'b1;
          req_count++;
        end
        wait_cnt++;
      end
      if (dbg_state == ST_WAIT) begin
        if (respond && rsp_cnt >= rsp_wait) begin
          dbus_rsp_valid = 1'b1;
          dbus_rdata = rdata;
        end
        rsp_cnt++;
      end
      tick();
    end
    dbus_req_ready = 1'b0;
    dbus_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_load(32'h103, 2'b00, 1'b1, 5'd5);
    dbus_req_ready = 1'b1;
    tick(); tick();
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stall_o); end
    checks++; if (dbus_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b exp 0", dbus_req_valid); end
    checks++; if ({dbus_addr, dbus_we, dbus_wstrb, dbus_wdata} !== 69'h0) begin errors++; $display("FAIL reset_bus: got %h exp 0", {dbus_addr, dbus_we, dbus_wstrb, dbus_wdata}); end
    checks++; if ({wb_rd_addr, wb_reg_write, wb_data} !== 38'h0) begin errors++; $display("FAIL reset_wb: got %h exp 0", {wb_rd_addr, wb_reg_write, wb_data}); end
    checks++; if ({misalign_o, bus_err_o} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b exp 00", {misalign_o, bus_err_o}); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    drive_idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lb_signed();
    int sc, rc; bit st, dn, er; logic [68:0] seen; logic [68:0] eb; logic [37:0] ew;
    drive_load(32'h103, 2'b00, 1'b1, 5'd5);
    exp_q.push_back({5'd5, 1'b1, load_model(32'h103, 2'b00, 1'b1, 32'h80FF_1234)});
    bus_q.push_back({32'h100, 1'b0, 4'b0000, 32'h0});
    run_bus(0, 0, 32'h80FF_1234, 1'b1, sc, rc, st, seen, dn, er);
    checks++; if (!dn) begin errors++; $display("FAIL lb_done: DONE not reached"); end
    checks++; if (sc != 3) begin errors++; $display("FAIL lb_stall_cycles: got %0d exp 3", sc); end
    checks++; if (rc != 1) begin errors++; $display("FAIL lb_req_count: got %0d exp 1", rc); end
    eb = bus_q.pop_front();
    checks++; if (seen !== eb) begin errors++; $display("FAIL lb_bus_req: got %h exp %h", seen, eb); end
    tick();
    drive_idle();
    ew = exp_q.pop_front();
    checks++; if ({wb_rd_addr, wb_reg_write, wb_data} !== ew) begin errors++; $display("FAIL lb_wb: got %h exp %h", {wb_rd_addr, wb_reg_write, wb_data}, ew); end
    checks++; if (wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wb_value: got %h exp ffffff80", wb_data); end
    tick();
  endtask

  task automatic test_sh();
    int sc, rc; bit st, dn, er; logic [68:0] seen; logic [68:0] eb;
    drive_store(32'h202, 2'b01, 32'hDEAD_BEEF, 5'd9);
    bus_q.push_back({32'h200, 1'b1, 4'b1100, 32'hBEEF_BEEF});
    run_bus(0, 0, 32'h0, 1'b1, sc, rc, st, seen, dn, er);
    checks++; if (!dn) begin errors++; $display("FAIL sh_done: DONE not reached"); end
    eb = bus_q.pop_front();
    checks++; if (seen !== eb) begin errors++; $display("FAIL sh_bus_req: got %h exp %h", seen, eb); end
    checks++; if (sc != 3) begin errors++; $display("FAIL sh_stall_cycles: got %0d exp 3", sc); end
    tick();
    drive_idle();
    checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL sh_wb_write: got %b exp 0", wb_reg_write); end
    tick();
  endtask

  task automatic test_misalign();
    drive_load(32'h101, 2'b10, 1'b0, 5'd4);
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b exp 0", stall_o); end
    tick();
    drive_idle();
    checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b exp 1", misalign_o); end
    checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL mis_wb_write: got %b exp 0", wb_reg_write); end
    checks++; if (dbus_req_valid !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL mis_no_req: got valid %b state %0d exp 0 0", dbus_req_valid, dbg_state); end
    tick();
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got %b exp 0", misalign_o); end
  endtask

  task automatic test_ready_delay();
    int sc, rc; bit st, dn, er; logic [68:0] seen; logic [68:0] eb;
    drive_store(32'h301, 2'b00, 32'h0000_00A5, 5'd2);
    bus_q.push_back({32'h300, 1'b1, 4'b0010, 32'hA5A5_A5A5});
    run_bus(5, 3, 32'h0, 1'b1, sc, rc, st, seen, dn, er);
    checks++; if (!dn) begin errors++; $display("FAIL dly_done: DONE not reached"); end
    eb = bus_q.pop_front();
    checks++; if (seen !== eb) begin errors++; $display("FAIL dly_bus_req: got %h exp %h", seen, eb); end
    checks++; if (!st) begin errors++; $display("FAIL dly_stable: got unstable exp stable"); end
    checks++; if (rc != 1) begin errors++; $display("FAIL dly_req_count: got %0d exp 1", rc); end
    checks++; if (sc != 11) begin errors++; $display("FAIL dly_stall_cycles: got %0d exp 11", sc); end
    tick();
    drive_idle();
    checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL dly_wb_write: got %b exp 0", wb_reg_write); end
    tick();
  endtask

  task automatic test_timeout();
    int sc, rc; bit st, dn, er; logic [68:0] seen; logic [68:0] eb;
    drive_load(32'h400, 2'b10, 1'b0, 5'd6);
    bus_q.push_back({32'h400, 1'b0, 4'b0000, 32'h0});
    run_bus(0, 0, 32'h0, 1'b0, sc, rc, st, seen, dn, er);
    checks++; if (!dn) begin errors++; $display("FAIL to_done: DONE not reached"); end
    checks++; if (!er) begin errors++; $display("FAIL to_bus_err: got 0 exp 1"); end
    checks++; if (sc != TO + 2) begin errors++; $display("FAIL to_stall_cycles: got %0d exp %0d", sc, TO + 2); end
    eb = bus_q.pop_front();
    checks++; if (seen !== eb || rc != 1) begin errors++; $display("FAIL to_bus_req: got %h count %0d exp %h count 1", seen, rc, eb); end
    tick();
    drive_idle();
    checks++; if (wb_reg_write !== 1'b0 || bus_err_o !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL to_after: got we %b err %b state %0d exp 0 0 0", wb_reg_write, bus_err_o, dbg_state); end
    dbus_rsp_valid = 1'b1;
    dbus_rdata = 32'hFFFF_FFFF;
    tick();
    dbus_rsp_valid = 1'b0;
    checks++; if (dbg_state !== ST_IDLE || stall_o !== 1'b0 || wb_reg_write !== 1'b0) begin errors++; $display("FAIL to_late_rsp: got state %0d stall %b we %b exp 0 0 0", dbg_state, stall_o, wb_reg_write); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs[3] = '{32'h101, 32'h106, 32'h10C};
    logic [1:0]  sizes[3] = '{2'b00, 2'b01, 2'b10};
    logic        sgns[3]  = '{1'b0, 1'b1, 1'b0};
    logic [31:0] rdats[3] = '{32'h80FF_1234, 32'h8001_7FFE, 32'hCAFE_F00D};
    int sc, rc; bit st, dn, er; logic [68:0] seen; logic [68:0] eb; logic [37:0] ew;
    for (int i = 0; i < 3; i++) begin
      drive_load(addrs[i], sizes[i], sgns[i], 5'(i + 10));
      exp_q.push_back({5'(i + 10), 1'b1, load_model(addrs[i], sizes[i], sgns[i], rdats[i])});
      bus_q.push_back({addrs[i] & 32'hFFFF_FFFC, 1'b0, 4'b0000, 32'h0});
      run_bus(0, 0, rdats[i], 1'b1, sc, rc, st, seen, dn, er);
      eb = bus_q.pop_front();
      checks++; if (!dn || seen !== eb) begin errors++; $display("FAIL b2b_req%0d: got %h done %b exp %h", i, seen, dn, eb); end
      tick();
      ew = exp_q.pop_front();
      checks++; if ({wb_rd_addr, wb_reg_write, wb_data} !== ew) begin errors++; $display("FAIL b2b_wb%0d: got %h exp %h", i, {wb_rd_addr, wb_reg_write, wb_data}, ew); end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_alu();
    logic [31:0] res[5]  = '{32'h1234, 32'h1, 32'h5, 32'h9, 32'h55};
    logic [1:0]  sel[5]  = '{2'b00, 2'b10, 2'b11, 2'b00, 2'b00};
    logic [31:0] cand[5] = '{32'hAAAA, 32'h2004, 32'h7777, 32'h0, 32'h0};
    logic [4:0]  rd[5]   = '{5'd3, 5'd1, 5'd0, 5'd8, 5'd2};
    logic        we[5]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        csr[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp_d;
    logic [37:0] ew;
    for (int i = 0; i < 5; i++) begin
      drive_alu(res[i], sel[i], cand[i], rd[i], we[i], csr[i], 32'hC0FF_EE00);
      exp_d = csr[i] ? 32'hC0FF_EE00 : (sel[i][1] ? cand[i] : res[i]);
      exp_q.push_back({rd[i], we[i], exp_d});
      tick();
      ew = exp_q.pop_front();
      checks++; if ({wb_rd_addr, wb_reg_write, wb_data} !== ew) begin errors++; $display("FAIL alu_wb%0d: got %h exp %h", i, {wb_rd_addr, wb_reg_write, wb_data}, ew); end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    logic [37:0] ew;
    drive_load(32'h500, 2'b10, 1'b0, 5'd10);
    dbus_req_ready = 1'b1;
    tick();
    tick();
    dbus_req_ready = 1'b0;
    checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL rmw_in_wait: got %0d exp 2", dbg_state); end
    rst_n = 1'b0;
    tick();
    checks++; if ({stall_o, dbus_req_valid, wb_reg_write, wb_data, misalign_o, bus_err_o} !== 37'h0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL rmw_reset: got stall %b valid %b we %b data %h state %0d exp all 0", stall_o, dbus_req_valid, wb_reg_write, wb_data, dbg_state); end
    rst_n = 1'b1;
    drive_alu(32'h42, 2'b00, 32'h0, 5'd7, 1'b1, 1'b0, 32'h0);
    exp_q.push_back({5'd7, 1'b1, 32'h42});
    tick();
    ew = exp_q.pop_front();
    checks++; if ({wb_rd_addr, wb_reg_write, wb_data} !== ew) begin errors++; $display("FAIL rmw_alu_wb: got %h exp %h", {wb_rd_addr, wb_reg_write, wb_data}, ew); end
    drive_idle();
    tick();
  endtask

  // Test sequence and final report.
  initial begin
    drive_idle();
    test_reset();
    test_lb_signed();
    test_sh();
    test_misalign();
    test_ready_delay();
    test_timeout();
    test_back_to_back();
    test_alu();
    test_reset_mid_wait();
    checks++; if (exp_q.size() != 0 || bus_q.size() != 0) begin errors++; $display("FAIL queues_drained: got %0d/%0d exp 0/0", exp_q.size(), bus_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit. It consumes the instruction held in the EX/MEM pipeline register and issues word-aligned requests on a valid/ready data bus.
- It aligns and sign-extends load data and builds store byte strobes.
- It registers the selected write-back result toward WB, acting as the MEM/WB boundary.
- It raises stall_o to freeze the upstream pipeline while a bus access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT before the access is aborted with an error.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- mem_alu_result  in  32  effective address, or ALU result for non-memory ops
- mem_rs2_val_for_store  in  32  store data, low bits significant
- mem_rd_addr  in  5  destination register
- mem_reg_write  in  1  instruction writes rd
- mem_mem_read  in  1  load
- mem_mem_write  in  1  store
- mem_wb_sel  in  2  00 ALU, 01 load data, 10/11 wb_candidate
- mem_load_size  in  2  00 byte, 01 half, 10/11 word
- mem_store_size  in  2  same encoding as mem_load_size
- mem_load_signed  in  1  sign-extend load data
- mem_wb_candidate  in  32  precomputed non-memory result (e.g. PC+4)
- mem_csr_hit  in  1  CSR read result overrides wb_sel
- mem_csr_data  in  32  CSR read data
- dbus_req_valid  out  1  request valid
- dbus_req_ready  in  1  bus accepts request
- dbus_addr  out  32  {addr[31:2],2'b00}
- dbus_we  out  1  1 = write
- dbus_wstrb  out  4  byte enables (0000 on reads)
- dbus_wdata  out  32  lane-replicated store data
- dbus_rsp_valid  in  1  response/ack
- dbus_rdata  in  32  read data word
- stall_o  out  1  hold PC/IF/ID/EX/MEM registers
- wb_rd_addr  out  5  registered rd
- wb_reg_write  out  1  registered write enable
- wb_data  out  32  registered write-back value
- misalign_o  out  1  one-cycle pulse, misaligned access
- bus_err_o  out  1  one-cycle pulse, timeout

Behaviour:
- All outputs reset to 0 on the rising clk edge with rst_n=0; the FSM resets to IDLE.
- A reset applied mid-access abandons the access. A response that arrives while in IDLE is ignored.
- Access condition: acc = mem_mem_read | mem_mem_write. If both are set, the access is treated as a store.
- Misaligned: half-size with addr[0]=1, or word-size with addr[1:0]≠0.
  - No bus request is issued; stall_o=0.
  - misalign_o=1 in the following cycle.
  - wb_reg_write=0 for that instruction.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If acc and aligned: latch addr, size, signed, we, wdata, strb, rd, reg_write and wb_sel; go to REQ.
  - Otherwise (non-memory op): wb_* load next edge.
  - wb_data = csr_data if csr_hit; else alu_result for 00; else wb_candidate for 10/11.
- REQ: dbus_req_valid=1 with stable addr, we, wstrb and wdata. On dbus_req_ready go to WAIT. Valid is never withdrawn before ready.
- WAIT:
  - Timeout counter clears on entry to WAIT and increments each cycle.
  - On dbus_rsp_valid: latch dbus_rdata and go to DONE.
  - When the counter reaches TIMEOUT_CYCLES-1 without a response: go to DONE with data 0 and pulse bus_err_o; wb_reg_write=0.
  - A response in the same cycle as acceptance is not expected.
- DONE:
  - stall_o=0; no new request is issued, even though EX/MEM still holds the same instruction.
  - wb_* load at the DONE edge. For loads, wb_data is the extracted load data, overridden by csr_data if csr_hit. For stores, wb_reg_write=0.
  - Next state is IDLE.
- stall_o = (IDLE & acc & aligned) | REQ | WAIT. It is combinational.
- Load extract, with lane = addr[1:0]:
  - byte = rdata[8*lane+:8]
  - half = rdata[16*addr[1]+:16]
  - word = rdata
  - Zero-extend or sign-extend to 32 bits per load_signed.
- Store data and strobes:
  - byte: wdata = {4{rs2[7:0]}}, wstrb = 0001<<lane.
  - half: wdata = {2{rs2[15:0]}}, wstrb = 0011<<lane.
  - word: wdata = rs2, wstrb = 1111.
- rd=x0: wb_reg_write passes through unchanged; the register file ignores x0.
- Minimum load latency, with the instruction presented at T0:
  - T1: REQ; with ready asserted, the request is accepted.
  - T2: WAIT; with the response asserted, the FSM moves to DONE.
  - T3: DONE.
  - T4: wb_* valid.

Test Plan:
- LB signed at addr 0x103, rdata 0x80FF_1234, ready and rsp immediate → dbus_addr 0x100, wstrb 0000, wb_data 0xFFFF_FF80, stall_o high for exactly T0–T2.
- SH at addr 0x202, rs2 0xDEAD_BEEF → dbus_we=1, wstrb 1100, wdata 0xBEEF_BEEF; wb_reg_write=0 after DONE.
- LW at addr 0x101 → no dbus_req_valid, misalign_o pulse, stall_o=0, wb_reg_write=0.
- ready held low 5 cycles, then rsp 3 cycles later → req_valid, addr and wdata stable throughout; stall_o held; one bus transaction only.
- No rsp for TIMEOUT_CYCLES (255) → bus_err_o pulse, FSM returns to IDLE, wb_reg_write=0; a late rsp is ignored.
- rst_n low during WAIT → all outputs 0, FSM in IDLE; a subsequent ALU op with alu_result 0x42 and wb_sel 00 gives wb_data 0x42 one cycle later.
